// File: rtl/lcd_pkg.sv
// Shared constants and state encodings for the HD44780 text driver.
package lcd_pkg;

    localparam logic [7:0] CMD_FUNCSET = 8'h38;
    localparam logic [7:0] CMD_DISPON  = 8'h0C;
    localparam logic [7:0] CMD_ENTRY   = 8'h06;
    localparam logic [7:0] CMD_CLEAR   = 8'h01;
    localparam logic [7:0] CMD_LINE1   = 8'h80;
    localparam logic [7:0] CMD_LINE2   = 8'hC0;

    typedef enum logic [2:0] {
        ST_POWERUP,
        ST_INIT,
        ST_IDLE,
        ST_ADDR1,
        ST_LINE1,
        ST_ADDR2,
        ST_LINE2
    } lcd_state_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_SETUP,
        WR_PULSE,
        WR_WAIT
    } wr_phase_t;

    function automatic logic [7:0] init_cmd(input logic [1:0] step);
        case (step)
            2'd0:    return CMD_FUNCSET;
            2'd1:    return CMD_DISPON;
            2'd2:    return CMD_ENTRY;
            default: return CMD_CLEAR;
        endcase
    endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// One-byte HD44780 write: setup cycle, E strobe, then a post-strobe wait.
// Clear Display gets the long wait; everything else the short one.
module lcd_byte_writer
    import lcd_pkg::*;
#(
    parameter int E_PULSE_CYCLES    = 25,
    parameter int CMD_WAIT_CYCLES   = 2500,
    parameter int CLEAR_WAIT_CYCLES = 100000
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] data,
    output logic       idle,
    output logic       done,
    output logic       LCD_RS,
    output logic       LCD_E,
    output logic [7:0] LCD_DATA
);

    localparam int MAX_A = (CLEAR_WAIT_CYCLES > CMD_WAIT_CYCLES) ? CLEAR_WAIT_CYCLES : CMD_WAIT_CYCLES;
    localparam int MAX_C = (MAX_A > E_PULSE_CYCLES) ? MAX_A : E_PULSE_CYCLES;
    localparam int CW    = $clog2(MAX_C + 1);

    wr_phase_t    phase, phase_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          e_nxt;
    logic          load;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            phase    <= WR_IDLE;
            cnt      <= '0;
            LCD_E    <= 1'b0;
            LCD_RS   <= 1'b0;
            LCD_DATA <= 8'h00;
        end else begin
            phase <= phase_nxt;
            cnt   <= cnt_nxt;
            LCD_E <= e_nxt;
            if (load) begin
                LCD_RS   <= rs;
                LCD_DATA <= data;
            end
        end
    end

    always_comb begin
        phase_nxt = phase;
        cnt_nxt   = cnt;
        e_nxt     = LCD_E;
        load      = 1'b0;
        case (phase)
            WR_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    phase_nxt = WR_SETUP;
                end
            end
            WR_SETUP: begin
                phase_nxt = WR_PULSE;
                cnt_nxt   = CW'(E_PULSE_CYCLES - 1);
                e_nxt     = 1'b1;
            end
            WR_PULSE: begin
                if (cnt == '0) begin
                    e_nxt     = 1'b0;
                    phase_nxt = WR_WAIT;
                    if (!LCD_RS && LCD_DATA == CMD_CLEAR)
                        cnt_nxt = CW'(CLEAR_WAIT_CYCLES - 1);
                    else
                        cnt_nxt = CW'(CMD_WAIT_CYCLES - 1);
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            WR_WAIT: begin
                if (cnt == '0)
                    phase_nxt = WR_IDLE;
                else
                    cnt_nxt = cnt - CW'(1);
            end
            default: phase_nxt = WR_IDLE;
        endcase
    end

    assign idle = (phase == WR_IDLE);
    assign done = (phase == WR_WAIT) && (cnt == '0);

endmodule

// File: rtl/lcd_text_driver.sv
// HD44780 16x2 text driver: power-up delay, init commands, then full-screen
// rewrite from a snapshot whenever the input text differs from what is shown.
//
//   state   | meaning
//   POWERUP | wait for the LCD controller to come out of its own reset
//   INIT    | function set, display on, entry mode, clear
//   IDLE    | screen matches text; watch for a change
//   ADDR1   | set DDRAM address to line 1
//   LINE1   | write snapshot characters 0..15
//   ADDR2   | set DDRAM address to line 2
//   LINE2   | write snapshot characters 16..31
module lcd_text_driver
    import lcd_pkg::*;
#(
    parameter int POWERUP_CYCLES    = 750000,
    parameter int E_PULSE_CYCLES    = 25,
    parameter int CMD_WAIT_CYCLES   = 2500,
    parameter int CLEAR_WAIT_CYCLES = 100000
) (
    input  logic         CLK,
    input  logic         Reset,
    input  logic [255:0] characters,
    output logic         busy,
    output logic         LCD_RS,
    output logic         LCD_RW,
    output logic         LCD_E,
    output logic [7:0]   LCD_DATA
);

    localparam int PW = $clog2(POWERUP_CYCLES + 1);

    lcd_state_t     state, state_nxt;
    logic [4:0]     idx, idx_nxt;
    logic [PW-1:0]  pwr_cnt, pwr_nxt;
    logic           dirty, dirty_nxt;
    logic [255:0]   snapshot, shown;
    logic           take_snap, commit;
    logic           wr_start, wr_rs, wr_idle, wr_done;
    logic [7:0]     wr_byte;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state    <= ST_POWERUP;
            idx      <= '0;
            pwr_cnt  <= '0;
            dirty    <= 1'b1;
            snapshot <= '0;
            shown    <= '0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            pwr_cnt <= pwr_nxt;
            dirty   <= dirty_nxt;
            if (take_snap) snapshot <= characters;
            if (commit)    shown    <= snapshot;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        pwr_nxt   = pwr_cnt;
        dirty_nxt = dirty;
        take_snap = 1'b0;
        commit    = 1'b0;
        wr_start  = 1'b0;
        wr_rs     = 1'b0;
        wr_byte   = 8'h00;
        case (state)
            ST_POWERUP: begin
                if (pwr_cnt == PW'(POWERUP_CYCLES - 1)) begin
                    pwr_nxt   = '0;
                    state_nxt = ST_INIT;
                end else begin
                    pwr_nxt = pwr_cnt + PW'(1);
                end
            end
            ST_INIT: begin
                wr_byte  = init_cmd(idx[1:0]);
                wr_start = wr_idle;
                if (wr_done) begin
                    if (idx == 5'd3) begin
                        idx_nxt   = '0;
                        state_nxt = ST_IDLE;
                    end else begin
                        idx_nxt = idx + 5'd1;
                    end
                end
            end
            ST_IDLE: begin
                if (dirty || characters != shown) begin
                    take_snap = 1'b1;
                    dirty_nxt = 1'b0;
                    state_nxt = ST_ADDR1;
                end
            end
            ST_ADDR1: begin
                wr_byte  = CMD_LINE1;
                wr_start = wr_idle;
                if (wr_done) begin
                    idx_nxt   = '0;
                    state_nxt = ST_LINE1;
                end
            end
            ST_LINE1: begin
                wr_rs    = 1'b1;
                wr_byte  = snapshot[{idx, 3'b000} +: 8];
                wr_start = wr_idle;
                if (wr_done) begin
                    // 15 -> 16 carries straight into line 2's first index
                    idx_nxt = idx + 5'd1;
                    if (idx == 5'd15) state_nxt = ST_ADDR2;
                end
            end
            ST_ADDR2: begin
                wr_byte  = CMD_LINE2;
                wr_start = wr_idle;
                if (wr_done) state_nxt = ST_LINE2;
            end
            ST_LINE2: begin
                wr_rs    = 1'b1;
                wr_byte  = snapshot[{idx, 3'b000} +: 8];
                wr_start = wr_idle;
                if (wr_done) begin
                    if (idx == 5'd31) begin
                        idx_nxt   = '0;
                        commit    = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        idx_nxt = idx + 5'd1;
                    end
                end
            end
            default: state_nxt = ST_POWERUP;
        endcase
    end

    assign busy   = (state != ST_IDLE);
    assign LCD_RW = 1'b0;

    lcd_byte_writer #(
        .E_PULSE_CYCLES   (E_PULSE_CYCLES),
        .CMD_WAIT_CYCLES  (CMD_WAIT_CYCLES),
        .CLEAR_WAIT_CYCLES(CLEAR_WAIT_CYCLES)
    ) u_writer (
        .CLK     (CLK),
        .Reset   (Reset),
        .start   (wr_start),
        .rs      (wr_rs),
        .data    (wr_byte),
        .idle    (wr_idle),
        .done    (wr_done),
        .LCD_RS  (LCD_RS),
        .LCD_E   (LCD_E),
        .LCD_DATA(LCD_DATA)
    );

endmodule

// File: tb/tb_lcd_text_driver.sv
// Bench for lcd_text_driver: records every E strobe and compares the strobe
// stream against the expected LCD command/data sequence built from the text.
module tb_lcd_text_driver;

    localparam int P   = 20;
    localparam int EP  = 2;
    localparam int CMD = 4;
    localparam int CLR = 10;

    logic         CLK = 1'b0;
    logic         Reset;
    logic [255:0] characters;
    logic         busy, LCD_RS, LCD_RW, LCD_E;
    logic [7:0]   LCD_DATA;

    lcd_text_driver #(
        .POWERUP_CYCLES   (P),
        .E_PULSE_CYCLES   (EP),
        .CMD_WAIT_CYCLES  (CMD),
        .CLEAR_WAIT_CYCLES(CLR)
    ) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .characters(characters),
        .busy      (busy),
        .LCD_RS    (LCD_RS),
        .LCD_RW    (LCD_RW),
        .LCD_E     (LCD_E),
        .LCD_DATA  (LCD_DATA)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc++;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         width;
        int         gap;
        logic       stable;
        logic       busy;
    } pulse_t;

    typedef struct {
        logic       rs;
        logic [7:0] b;
    } xb_t;
    typedef xb_t xq_t[$];

    pulse_t     pq[$];
    pulse_t     cur;
    logic       e_prev = 1'b0;
    logic       open_p = 1'b0;
    logic       prev_rs = 1'b0;
    logic [7:0] prev_data = 8'h00;
    int         last_fall = 0;
    int         width = 0;

    // Strobe recorder, sampled on the falling edge
    always @(negedge CLK) begin
        if (Reset) begin
            open_p    = 1'b0;
            e_prev    = 1'b0;
            last_fall = cyc;
        end else begin
            if (LCD_E && !e_prev) begin
                cur.rs     = LCD_RS;
                cur.data   = LCD_DATA;
                cur.gap    = cyc - last_fall;
                cur.stable = (LCD_RS == prev_rs) && (LCD_DATA == prev_data);
                cur.busy   = busy;
                width      = 1;
                open_p     = 1'b1;
            end else if (LCD_E && e_prev) begin
                width++;
                if (LCD_RS != cur.rs || LCD_DATA != cur.data) cur.stable = 1'b0;
            end else if (!LCD_E && e_prev && open_p) begin
                cur.width = width;
                pq.push_back(cur);
                last_fall = cyc;
                open_p    = 1'b0;
            end
            e_prev = LCD_E;
        end
        prev_rs   = LCD_RS;
        prev_data = LCD_DATA;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    function automatic xq_t init_seq();
        xq_t q;
        q.push_back('{1'b0, 8'h38});
        q.push_back('{1'b0, 8'h0C});
        q.push_back('{1'b0, 8'h06});
        q.push_back('{1'b0, 8'h01});
        return q;
    endfunction

    // Address line 1, its 16 characters, address line 2, its 16 characters
    function automatic xq_t refresh_seq(input logic [255:0] t);
        xq_t q;
        for (int line = 0; line < 2; line++) begin
            q.push_back('{1'b0, (line == 0) ? 8'h80 : 8'hC0});
            for (int col = 0; col < 16; col++)
                q.push_back('{1'b1, t[8*(16*line + col) +: 8]});
        end
        return q;
    endfunction

    function automatic logic [255:0] text_of(input string l1, input string l2);
        logic [255:0] t;
        for (int i = 0; i < 16; i++) begin
            t[8*i +: 8]        = l1[i];
            t[8*(16 + i) +: 8] = l2[i];
        end
        return t;
    endfunction

    function automatic logic [255:0] rand_text();
        logic [255:0] t;
        for (int i = 0; i < 8; i++) t[32*i +: 32] = $urandom;
        return t;
    endfunction

    task automatic wait_pulses(input string tag, input int n, input int budget);
        int k = 0;
        while (pq.size() < n && k < budget) begin
            @(posedge CLK); #1;
            k++;
        end
        chk(tag, pq.size() >= n, 1'b1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin
            @(posedge CLK); #1;
            k++;
        end
        chk(tag, busy, 1'b0);
    endtask

    // Pops one recorded strobe per expected byte; gap lo < 0 skips the first gap check
    task automatic check_seq(input string tag, input xq_t exp, input int g_lo, input int g_hi);
        pulse_t p;
        int w;
        for (int k = 0; k < exp.size(); k++) begin
            if (pq.size() == 0) begin
                chk({tag, "_missing"}, pq.size(), exp.size() - k);
                break;
            end
            p = pq.pop_front();
            chk({tag, "_rs"}, p.rs, exp[k].rs);
            chk({tag, "_byte"}, p.data, exp[k].b);
            chk({tag, "_ewidth"}, p.width, EP);
            chk({tag, "_setup_hold"}, p.stable, 1'b1);
            chk({tag, "_busy"}, p.busy, 1'b1);
            if (k == 0) begin
                if (g_lo >= 0) chk_range({tag, "_gap0"}, p.gap, g_lo, g_hi);
            end else begin
                w = (!exp[k-1].rs && exp[k-1].b == 8'h01) ? CLR : CMD;
                chk_range({tag, "_gap"}, p.gap, w + 1, w + 4);
            end
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_e", LCD_E, 1'b0);
        chk("rst_rs", LCD_RS, 1'b0);
        chk("rst_rw", LCD_RW, 1'b0);
        chk("rst_data", LCD_DATA, 8'h00);
        chk("rst_busy", busy, 1'b1);
        Reset = 1'b0;
        pq.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] t0, ta, tb, tc, cap;
        int busy_hi;

        Reset      = 1'b1;
        t0         = rand_text();
        characters = t0;
        do_reset();

        // Power-up, init, and the automatic first refresh
        wait_pulses("init_timeout", 38, 3000);
        check_seq("init", init_seq(), P, P + 4);
        check_seq("first", refresh_seq(t0), -1, -1);
        wait_idle("first_busy_low", 200);

        // Room text
        cap        = text_of("    Cave of     ", "   Capochany    ");
        characters = cap;
        @(posedge CLK); #1;
        chk("busy_rises", busy, 1'b1);
        wait_pulses("cap_timeout", 34, 3000);
        check_seq("cap", refresh_seq(cap), -1, -1);
        wait_idle("cap_busy_low", 200);

        // Unchanged text: nothing happens
        busy_hi = 0;
        repeat (200) begin
            @(posedge CLK); #1;
            if (busy) busy_hi++;
        end
        chk("idle_pulses", pq.size(), 0);
        chk("idle_busy", busy_hi, 0);

        // Text change partway through LINE1
        ta         = rand_text();
        tb         = rand_text();
        tb[7:0]    = ~ta[7:0];
        characters = ta;
        wait_pulses("mid_timeout", 11, 1000);
        characters = tb;
        wait_pulses("mid2_timeout", 68, 3000);
        check_seq("old", refresh_seq(ta), -1, -1);
        check_seq("new", refresh_seq(tb), CMD + 1, CMD + 4);
        wait_idle("mid_busy_low", 200);
        repeat (100) @(posedge CLK);
        #1;
        chk("no_third_refresh", pq.size(), 0);

        // Reset while E is high in LINE2
        tc         = rand_text();
        characters = tc;
        begin
            int k = 0;
            while (!(pq.size() >= 21 && LCD_E) && k < 2000) begin
                @(posedge CLK); #1;
                k++;
            end
            chk("line2_e_high", LCD_E, 1'b1);
        end
        Reset = 1'b1;
        @(posedge CLK); #1;
        chk("rstmid_e", LCD_E, 1'b0);
        chk("rstmid_busy", busy, 1'b1);
        do_reset();
        wait_pulses("replay_timeout", 38, 3000);
        check_seq("replay_init", init_seq(), P, P + 4);
        check_seq("replay_ref", refresh_seq(tc), -1, -1);
        wait_idle("replay_busy_low", 200);
        chk("rw_low", LCD_RW, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
